// File: rtl/max_priority_scheduler_pkg.sv
// Shared types and helpers for the max-priority scheduler.
// Aging is enabled by defining MAX_PRIORITY_SCHEDULER_AGING_EN.
package max_priority_scheduler_pkg;

    localparam int DEF_N              = 4;
    localparam int DEF_PRIORITY_WIDTH = 3;
    localparam int DEF_AGE_WIDTH      = 4;

    localparam int INDEX_WIDTH  = DEF_N > 1 ? $clog2(DEF_N) : 1;
    localparam int PRIORITY_MAX = (1 << DEF_PRIORITY_WIDTH) - 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        GRANT
    } state_e;

    function automatic int unsigned sat_add(
        input int unsigned prio,
        input int unsigned age,
        input int unsigned pmax
    );
        int unsigned sum;
        sum = prio + age;
        return (sum > pmax) ? pmax : sum;
    endfunction

endpackage

// File: rtl/max_priority_scheduler_max_finder.sv
// Picks the highest value among the valid inputs; ties go to the lowest index.
// Outputs a one-hot location and the winning value.
module max_finder #(
    parameter int N           = 4,
    parameter int VALUE_WIDTH = 3
) (
    input  logic [N-1:0][VALUE_WIDTH-1:0] i_values,
    input  logic [N-1:0]                  i_valid,
    output logic [N-1:0]                  o_location,
    output logic [VALUE_WIDTH-1:0]        o_value
);

    logic found;

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        found      = 1'b0;
        o_value    = '0;
        o_location = '0;
        for (int i = 0; i < N; i++) begin
            if (i_valid[i] && (!found || i_values[i] > o_value)) begin
                found         = 1'b1;
                o_value       = i_values[i];
                o_location    = '0;
                o_location[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/max_priority_scheduler.sv
// Snapshot-based max-priority arbiter with a valid/ready grant port.
// Optional aging: define MAX_PRIORITY_SCHEDULER_AGING_EN.
module max_priority_scheduler
    import max_priority_scheduler_pkg::*;
#(
    parameter int N              = DEF_N,
    parameter int PRIORITY_WIDTH = DEF_PRIORITY_WIDTH,
    parameter int AGE_WIDTH      = DEF_AGE_WIDTH
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [N-1:0]                         i_request,
    input  logic [N-1:0][PRIORITY_WIDTH-1:0]     i_priority,
    output logic                                 o_grant_valid,
    input  logic                                 i_grant_ready,
    output logic [N-1:0]                         o_grant,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0]   o_grant_index,
    output logic [PRIORITY_WIDTH-1:0]            o_grant_priority,
    output logic                                 o_busy
);

    localparam int IW   = N > 1 ? $clog2(N) : 1;
    localparam int PMAX = (1 << PRIORITY_WIDTH) - 1;

    state_e                           state_q;
    logic [N-1:0]                     snap_req_q;
    logic [N-1:0][PRIORITY_WIDTH-1:0] snap_eff_q;
    logic [N-1:0][PRIORITY_WIDTH-1:0] eff_d;
    logic [N-1:0][PRIORITY_WIDTH-1:0] keys;
    logic [N-1:0]                     grant_q;
    logic [IW-1:0]                    index_q;
    logic [PRIORITY_WIDTH-1:0]        prio_q;
    logic                             valid_q;
    logic [N-1:0]                     loc;
    logic [PRIORITY_WIDTH-1:0]        win_val;
    logic [IW-1:0]                    loc_index;
    logic                             xfer;

    assign xfer = valid_q && i_grant_ready;

`ifdef MAX_PRIORITY_SCHEDULER_AGING_EN
    logic [N-1:0][AGE_WIDTH-1:0] age_q;
    logic [N-1:0][AGE_WIDTH-1:0] age_d;

    // A back-to-back snapshot already sees the ages updated by this transfer.
    always_comb begin
        age_d = age_q;
        if (state_q == GRANT && xfer) begin
            for (int i = 0; i < N; i++) begin
                if (grant_q[i] || !snap_req_q[i]) begin
                    age_d[i] = '0;
                end else if (age_q[i] != '1) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        eff_d = '0;
        for (int i = 0; i < N; i++) begin
            eff_d[i] = PRIORITY_WIDTH'(sat_add(32'(i_priority[i]),
                                               32'(age_d[i]), PMAX));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign eff_d = i_priority;
`endif

    always_comb begin
        keys = '0;
        for (int i = 0; i < N; i++) begin
            keys[i] = snap_req_q[i] ? snap_eff_q[i] : '0;
        end
    end

    max_finder #(
        .N           (N),
        .VALUE_WIDTH (PRIORITY_WIDTH)
    ) u_max_finder (
        .i_values   (keys),
        .i_valid    (snap_req_q),
        .o_location (loc),
        .o_value    (win_val)
    );

    always_comb begin
        loc_index = '0;
        for (int i = 0; i < N; i++) begin
            if (loc[i]) begin
                loc_index = IW'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            snap_req_q <= '0;
            snap_eff_q <= '0;
            grant_q    <= '0;
            index_q    <= '0;
            prio_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|i_request) begin
                        snap_req_q <= i_request;
                        snap_eff_q <= eff_d;
                        state_q    <= COMPARE;
                    end
                end
                COMPARE: begin
                    grant_q <= loc;
                    index_q <= loc_index;
                    prio_q  <= win_val;
                    valid_q <= 1'b1;
                    state_q <= GRANT;
                end
                GRANT: begin
                    if (xfer) begin
                        grant_q <= '0;
                        index_q <= '0;
                        prio_q  <= '0;
                        valid_q <= 1'b0;
                        if (|i_request) begin
                            snap_req_q <= i_request;
                            snap_eff_q <= eff_d;
                            state_q    <= COMPARE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_grant_valid    = valid_q;
    assign o_grant          = grant_q;
    assign o_grant_index    = index_q;
    assign o_grant_priority = prio_q;
    assign o_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_max_priority_scheduler.sv
// Directed self-checking bench for max_priority_scheduler (N=4, PW=3).
// Aging scenario runs only when MAX_PRIORITY_SCHEDULER_AGING_EN is defined.
module tb_max_priority_scheduler;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req;
    logic [3:0][2:0] prio;
    logic            ready;
    logic            gvalid;
    logic [3:0]      grant;
    logic [1:0]      gidx;
    logic [2:0]      gprio;
    logic            busy;

    int errors = 0;
    int checks = 0;

    max_priority_scheduler #(
        .N              (4),
        .PRIORITY_WIDTH (3),
        .AGE_WIDTH      (4)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_request        (req),
        .i_priority       (prio),
        .o_grant_valid    (gvalid),
        .i_grant_ready    (ready),
        .o_grant          (grant),
        .o_grant_index    (gidx),
        .o_grant_priority (gprio),
        .o_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(gvalid), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_index"}, 32'(gidx), 32'd0);
        chk({tag, "_prio"}, 32'(gprio), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        prio  = '0;
        ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // single request
        prio[2] = 3'd5;
        req     = 4'b0100;
        tick();
        chk("single_snap_valid", 32'(gvalid), 32'd0);
        chk("single_snap_busy", 32'(busy), 32'd1);
        tick();
        chk("single_valid", 32'(gvalid), 32'd1);
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_index", 32'(gidx), 32'd2);
        chk("single_prio", 32'(gprio), 32'd5);
        ready = 1'b1;
        req   = '0;
        tick();
        chk("single_done_valid", 32'(gvalid), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);
        ready = 1'b0;

        // four-way tie, held grant, late input changes ignored
        prio = {3'd3, 3'd3, 3'd3, 3'd3};
        req  = 4'b1111;
        tick();
        tick();
        chk("tie_grant", 32'(grant), 32'h1);
        chk("tie_index", 32'(gidx), 32'd0);
        chk("tie_prio", 32'(gprio), 32'd3);
        req  = 4'b1000;
        prio = {3'd7, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("tie_hold_valid", 32'(gvalid), 32'd1);
            chk("tie_hold_grant", 32'(grant), 32'h1);
            chk("tie_hold_prio", 32'(gprio), 32'd3);
        end
        ready = 1'b1;
        req   = '0;
        tick();
        chk("tie_done_valid", 32'(gvalid), 32'd0);
        chk("tie_done_grant", 32'(grant), 32'd0);

        // back-to-back with ready held high
        prio = {3'd6, 3'd0, 3'd2, 3'd0};
        req  = 4'b1010;
        tick();
        tick();
        chk("b2b_1_valid", 32'(gvalid), 32'd1);
        chk("b2b_1_grant", 32'(grant), 32'h8);
        chk("b2b_1_index", 32'(gidx), 32'd3);
        tick();
        chk("b2b_gap_valid", 32'(gvalid), 32'd0);
        chk("b2b_gap_grant", 32'(grant), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd1);
        tick();
        chk("b2b_2_valid", 32'(gvalid), 32'd1);
        chk("b2b_2_grant", 32'(grant), 32'h8);
        req = '0;
        tick();
        chk("b2b_done_busy", 32'(busy), 32'd0);

        // reset while a grant is pending
        ready   = 1'b0;
        prio[0] = 3'd4;
        req     = 4'b0001;
        tick();
        tick();
        chk("rst_pre_valid", 32'(gvalid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_idle_outputs("rst_mid");
        rst_n = 1'b1;
        req   = '0;
        tick();
        chk("rst_after_busy", 32'(busy), 32'd0);

`ifdef MAX_PRIORITY_SCHEDULER_AGING_EN
        // requester 0 ages from 1 up to tie requester 1 at effective 4
        prio  = {3'd0, 3'd0, 3'd4, 3'd1};
        req   = 4'b0011;
        ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("age_valid", 32'(gvalid), 32'd1);
            chk("age_grant", 32'(grant), (k < 3) ? 32'h2 : 32'h1);
            chk("age_prio", 32'(gprio), 32'd4);
            if (k == 3) begin
                req = '0;
            end
            tick();
            chk("age_gap_valid", 32'(gvalid), 32'd0);
        end
        chk("age_done_busy", 32'(busy), 32'd0);
        ready = 1'b0;
`endif

        // request withdrawn during grant is still served
        prio = {3'd0, 3'd0, 3'd1, 3'd0};
        req  = 4'b0010;
        tick();
        req = '0;
        tick();
        chk("wd_valid", 32'(gvalid), 32'd1);
        chk("wd_grant", 32'(grant), 32'h2);
        chk("wd_index", 32'(gidx), 32'd1);
        tick();
        tick();
        chk("wd_hold_grant", 32'(grant), 32'h2);
        chk("wd_hold_valid", 32'(gvalid), 32'd1);
        ready = 1'b1;
        tick();
        chk("wd_done_valid", 32'(gvalid), 32'd0);
        chk("wd_done_busy", 32'(busy), 32'd0);
        ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
